// File: rtl/unidad_riesgos_param_pkg.sv
// Shared types for the hazard unit: FSM state encoding and operand-forward selects.
package unidad_riesgos_param_pkg;

  typedef enum logic {
    NORMAL = 1'b0,
    ESPERA = 1'b1
  } estado_t;

  localparam logic [1:0] FW_RF = 2'b00;
  localparam logic [1:0] FW_W  = 2'b01;
  localparam logic [1:0] FW_M  = 2'b10;

  // Wide enough for the largest extra load latency (7).
  localparam int LAT_W = 3;

endpackage

// File: rtl/unidad_riesgos_param_selector_adelanto.sv
// Per-operand forward select for the Execute stage; Memory takes priority over Writeback.
module selector_adelanto
  import unidad_riesgos_param_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              habilitar,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rd_m,
  input  logic [ADDR_W-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output logic [1:0]        sel
);

  always_comb begin
    // NOTE: assigning a default before any branch keeps this purely combinational (no latch).
    sel = FW_RF;
    if (habilitar && (rs != '0)) begin
      if (reg_write_m && (rs == rd_m)) begin
        sel = FW_M;
      end else if (reg_write_w && (rs == rd_w)) begin
        sel = FW_W;
      end
    end
  end

endmodule

// File: rtl/unidad_riesgos_param.sv
// Pipeline hazard unit: forwarding/interlock mode, load-use stall with configurable
// extra memory latency, branch flush, and a saturating stall-cycle counter.
module unidad_riesgos_param
  import unidad_riesgos_param_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 0,
  parameter int CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              desactivar_fw_i,
  input  logic [ADDR_W-1:0] Rs1D_i,
  input  logic [ADDR_W-1:0] Rs2D_i,
  input  logic [ADDR_W-1:0] Rs1E_i,
  input  logic [ADDR_W-1:0] Rs2E_i,
  input  logic [ADDR_W-1:0] RdE_i,
  input  logic [ADDR_W-1:0] RdM_i,
  input  logic [ADDR_W-1:0] RdW_i,
  input  logic              RegWriteE_i,
  input  logic              RegWriteM_i,
  input  logic              RegWriteW_i,
  input  logic              CargaE_i,
  input  logic              PCSrcE_i,
  output logic [1:0]        ForwardAE_o,
  output logic [1:0]        ForwardBE_o,
  output logic              StallF_o,
  output logic              StallD_o,
  output logic              FlushD_o,
  output logic              FlushE_o,
  output logic              modo_fw_o,
  output logic [CNT_W-1:0]  contador_stall_o
);

  estado_t            estado, estado_sig;
  logic [LAT_W-1:0]   cuenta_lat, cuenta_sig;
  logic               uso_carga;
  logic               raw_interlock;
  logic               habilitar_fw;

  function automatic logic coincide(input logic [ADDR_W-1:0] rs,
                                    input logic [ADDR_W-1:0] rd,
                                    input logic              we);
    return we && (rs != '0) && (rs == rd);
  endfunction

  // Forwarding is suppressed while reset is held so the selects read 00.
  assign habilitar_fw = modo_fw_o & rst_n_i;

  selector_adelanto #(.ADDR_W(ADDR_W)) u_sel_a (
    .habilitar   (habilitar_fw),
    .rs          (Rs1E_i),
    .rd_m        (RdM_i),
    .rd_w        (RdW_i),
    .reg_write_m (RegWriteM_i),
    .reg_write_w (RegWriteW_i),
    .sel         (ForwardAE_o)
  );

  selector_adelanto #(.ADDR_W(ADDR_W)) u_sel_b (
    .habilitar   (habilitar_fw),
    .rs          (Rs2E_i),
    .rd_m        (RdM_i),
    .rd_w        (RdW_i),
    .reg_write_m (RegWriteM_i),
    .reg_write_w (RegWriteW_i),
    .sel         (ForwardBE_o)
  );

  assign uso_carga = CargaE_i && RegWriteE_i && (RdE_i != '0) &&
                     ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

  // Writeback writes the regfile in the first half-cycle, so only E and M can conflict.
  assign raw_interlock = !modo_fw_o &&
                         (coincide(Rs1D_i, RdE_i, RegWriteE_i) ||
                          coincide(Rs1D_i, RdM_i, RegWriteM_i) ||
                          coincide(Rs2D_i, RdE_i, RegWriteE_i) ||
                          coincide(Rs2D_i, RdM_i, RegWriteM_i));

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!rst_n_i) begin
      estado     <= NORMAL;
      cuenta_lat <= '0;
    end else begin
      estado     <= estado_sig;
      cuenta_lat <= cuenta_sig;
    end
  end

  always_comb begin
    estado_sig = estado;
    cuenta_sig = cuenta_lat;
    if (PCSrcE_i) begin
      estado_sig = NORMAL;
      cuenta_sig = '0;
    end else begin
      unique case (estado)
        NORMAL: begin
          if (uso_carga && (LOAD_LAT > 0)) begin
            estado_sig = ESPERA;
            cuenta_sig = LAT_W'(LOAD_LAT);
          end
        end
        ESPERA: begin
          if (cuenta_lat <= LAT_W'(1)) begin
            estado_sig = NORMAL;
            cuenta_sig = '0;
          end else begin
            cuenta_sig = cuenta_lat - LAT_W'(1);
          end
        end
        default: begin
          estado_sig = NORMAL;
          cuenta_sig = '0;
        end
      endcase
    end
  end

  // A taken branch overrides any stall in the same cycle.
  always_comb begin
    StallF_o = 1'b0;
    StallD_o = 1'b0;
    FlushD_o = 1'b0;
    FlushE_o = 1'b0;
    if (rst_n_i) begin
      if (PCSrcE_i) begin
        FlushD_o = 1'b1;
        FlushE_o = 1'b1;
      end else if ((estado == ESPERA) || uso_carga || raw_interlock) begin
        StallF_o = 1'b1;
        StallD_o = 1'b1;
        FlushE_o = 1'b1;
      end
    end
  end

  // Mode changes are deferred until the pipeline is not stalled.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      modo_fw_o <= 1'b1;
    end else if (!StallD_o && (estado == NORMAL)) begin
      modo_fw_o <= ~desactivar_fw_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      contador_stall_o <= '0;
    end else if (StallD_o && (contador_stall_o != '1)) begin
      contador_stall_o <= contador_stall_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_unidad_riesgos_param.sv
// Directed bench for the hazard unit: three instances (LOAD_LAT=0, LOAD_LAT=3, CNT_W=4) share stimulus.
module tb_unidad_riesgos_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       desactivar;
  logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic       rwe, rwm, rww, cargae, pcsrce;

  logic [1:0]  fa0, fb0, fa3, fb3, fac, fbc;
  logic        sf0, sd0, fd0, fe0, m0;
  logic        sf3, sd3, fd3, fe3, m3;
  logic        sfc, sdc, fdc, fec, mc;
  logic [31:0] cnt0, cnt3;
  logic [3:0]  cntc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  unidad_riesgos_param #(.ADDR_W(5), .LOAD_LAT(0), .CNT_W(32)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .desactivar_fw_i(desactivar),
    .Rs1D_i(rs1d), .Rs2D_i(rs2d), .Rs1E_i(rs1e), .Rs2E_i(rs2e),
    .RdE_i(rde), .RdM_i(rdm), .RdW_i(rdw),
    .RegWriteE_i(rwe), .RegWriteM_i(rwm), .RegWriteW_i(rww),
    .CargaE_i(cargae), .PCSrcE_i(pcsrce),
    .ForwardAE_o(fa0), .ForwardBE_o(fb0),
    .StallF_o(sf0), .StallD_o(sd0), .FlushD_o(fd0), .FlushE_o(fe0),
    .modo_fw_o(m0), .contador_stall_o(cnt0)
  );

  unidad_riesgos_param #(.ADDR_W(5), .LOAD_LAT(3), .CNT_W(32)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .desactivar_fw_i(desactivar),
    .Rs1D_i(rs1d), .Rs2D_i(rs2d), .Rs1E_i(rs1e), .Rs2E_i(rs2e),
    .RdE_i(rde), .RdM_i(rdm), .RdW_i(rdw),
    .RegWriteE_i(rwe), .RegWriteM_i(rwm), .RegWriteW_i(rww),
    .CargaE_i(cargae), .PCSrcE_i(pcsrce),
    .ForwardAE_o(fa3), .ForwardBE_o(fb3),
    .StallF_o(sf3), .StallD_o(sd3), .FlushD_o(fd3), .FlushE_o(fe3),
    .modo_fw_o(m3), .contador_stall_o(cnt3)
  );

  unidad_riesgos_param #(.ADDR_W(5), .LOAD_LAT(0), .CNT_W(4)) dutc (
    .clk_i(clk), .rst_n_i(rst_n), .desactivar_fw_i(desactivar),
    .Rs1D_i(rs1d), .Rs2D_i(rs2d), .Rs1E_i(rs1e), .Rs2E_i(rs2e),
    .RdE_i(rde), .RdM_i(rdm), .RdW_i(rdw),
    .RegWriteE_i(rwe), .RegWriteM_i(rwm), .RegWriteW_i(rww),
    .CargaE_i(cargae), .PCSrcE_i(pcsrce),
    .ForwardAE_o(fac), .ForwardBE_o(fbc),
    .StallF_o(sfc), .StallD_o(sdc), .FlushD_o(fdc), .FlushE_o(fec),
    .modo_fw_o(mc), .contador_stall_o(cntc)
  );

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_cmp++;
    if (obs !== esp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, esp, $time);
    end
  endtask

  task automatic limpiar();
    desactivar = 1'b0;
    rs1d = '0; rs2d = '0; rs1e = '0; rs2e = '0;
    rde = '0; rdm = '0; rdw = '0;
    rwe = 1'b0; rwm = 1'b0; rww = 1'b0;
    cargae = 1'b0; pcsrce = 1'b0;
  endtask

  // Leaves the bench at a falling edge with reset released and all DUTs in NORMAL.
  task automatic reiniciar();
    @(negedge clk);
    rst_n = 1'b0;
    limpiar();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic avanza();
    @(negedge clk);
  endtask

  task automatic pone_carga();
    cargae = 1'b1; rwe = 1'b1; rde = 5'd7; rs2d = 5'd7;
  endtask

  task automatic quita_carga();
    cargae = 1'b0; rwe = 1'b0; rde = '0; rs2d = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with hazard, forwarding and branch inputs all active.
    rst_n = 1'b0;
    limpiar();
    pone_carga();
    rs1e = 5'd5; rdm = 5'd5; rwm = 1'b1; pcsrce = 1'b1;
    @(negedge clk);
    #1;
    comprobar("rst_stallD", 32'(sd0), 32'd0);
    comprobar("rst_stallF", 32'(sf0), 32'd0);
    comprobar("rst_flushD", 32'(fd0), 32'd0);
    comprobar("rst_flushE", 32'(fe0), 32'd0);
    comprobar("rst_fwdA",   32'(fa0), 32'd0);
    comprobar("rst_modo",   32'(m0),  32'd1);
    comprobar("rst_cnt",    cnt0,     32'd0);
    rst_n = 1'b1;
    limpiar();

    // Forward selects, M priority over W, register zero never forwarded.
    rs1e = 5'd5; rs2e = 5'd5; rdm = 5'd5; rdw = 5'd5; rwm = 1'b1; rww = 1'b1;
    #1;
    comprobar("fwdA_M",      32'(fa0), 32'd2);
    comprobar("fwdB_M",      32'(fb0), 32'd2);
    comprobar("fwd_nostall", 32'(sd0), 32'd0);
    rdm = 5'd6;
    #1;
    comprobar("fwdA_W", 32'(fa0), 32'd1);
    rdm = 5'd5; rwm = 1'b0;
    #1;
    comprobar("fwdA_Woff_M", 32'(fa0), 32'd1);
    rwm = 1'b1; rs1e = 5'd0;
    #1;
    comprobar("fwdA_r0", 32'(fa0), 32'd0);
    comprobar("fwdB_M2", 32'(fb0), 32'd2);
    limpiar();
    avanza();

    // Load-use: one cycle with LOAD_LAT=0, four cycles with LOAD_LAT=3.
    pone_carga();
    #1;
    comprobar("lu0_stallF", 32'(sf0), 32'd1);
    comprobar("lu0_stallD", 32'(sd0), 32'd1);
    comprobar("lu0_flushE", 32'(fe0), 32'd1);
    comprobar("lu0_flushD", 32'(fd0), 32'd0);
    comprobar("lu0_cnt0",   cnt0,     32'd0);
    comprobar("lu3_c1",     32'(sd3), 32'd1);
    avanza();
    quita_carga();
    #1;
    comprobar("lu0_done",   32'(sd0), 32'd0);
    comprobar("lu0_cnt1",   cnt0,     32'd1);
    comprobar("lu3_c2",     32'(sd3), 32'd1);
    comprobar("lu3_c2_fe",  32'(fe3), 32'd1);
    avanza();
    #1;
    comprobar("lu3_c3",     32'(sd3), 32'd1);
    avanza();
    #1;
    comprobar("lu3_c4",     32'(sd3), 32'd1);
    comprobar("lu3_c4_sf",  32'(sf3), 32'd1);
    avanza();
    #1;
    comprobar("lu3_end",    32'(sd3), 32'd0);
    comprobar("lu3_end_fe", 32'(fe3), 32'd0);
    comprobar("lu3_cnt",    cnt3,     32'd4);

    // Branch in the second stall cycle cancels the remaining wait.
    reiniciar();
    pone_carga();
    #1;
    comprobar("br_c1", 32'(sd3), 32'd1);
    avanza();
    quita_carga();
    pcsrce = 1'b1;
    #1;
    comprobar("br_flushD", 32'(fd3), 32'd1);
    comprobar("br_flushE", 32'(fe3), 32'd1);
    comprobar("br_stallD", 32'(sd3), 32'd0);
    comprobar("br_stallF", 32'(sf3), 32'd0);
    avanza();
    pcsrce = 1'b0;
    #1;
    comprobar("br_normal", 32'(sd3), 32'd0);
    comprobar("br_flushD0", 32'(fd3), 32'd0);
    comprobar("br_cnt",    cnt3,     32'd1);

    // Mode request during ESPERA waits until the stall ends.
    reiniciar();
    pone_carga();
    avanza();
    quita_carga();
    desactivar = 1'b1;
    #1;
    comprobar("md_c2", 32'(m3), 32'd1);
    avanza();
    #1;
    comprobar("md_c3", 32'(m3), 32'd1);
    avanza();
    #1;
    comprobar("md_c4", 32'(m3), 32'd1);
    comprobar("md_c4_sd", 32'(sd3), 32'd1);
    avanza();
    #1;
    comprobar("md_c5_sd",  32'(sd3), 32'd0);
    comprobar("md_c5_m",   32'(m3),  32'd1);
    comprobar("md_c5_cnt", cnt3,     32'd4);
    avanza();
    #1;
    comprobar("md_off", 32'(m3), 32'd0);
    rdm = 5'd3; rwm = 1'b1; rs1d = 5'd3; rs1e = 5'd3;
    #1;
    comprobar("il_stallD", 32'(sd3), 32'd1);
    comprobar("il_flushE", 32'(fe3), 32'd1);
    comprobar("il_fwdA",   32'(fa3), 32'd0);
    rdm = 5'd0; rwm = 1'b0; rdw = 5'd3; rww = 1'b1;
    #1;
    comprobar("il_W_nostall", 32'(sd3), 32'd0);
    // Re-enable request blocked by an interlock stall.
    rdw = 5'd0; rww = 1'b0; rdm = 5'd3; rwm = 1'b1;
    desactivar = 1'b0;
    avanza();
    #1;
    comprobar("md_blocked", 32'(m3), 32'd0);
    rdm = 5'd0; rwm = 1'b0;
    avanza();
    #1;
    comprobar("md_on", 32'(m3), 32'd1);

    // Reset in the middle of ESPERA.
    reiniciar();
    pone_carga();
    avanza();
    quita_carga();
    #1;
    comprobar("rm_espera", 32'(sd3), 32'd1);
    rst_n = 1'b0;
    #1;
    comprobar("rm_rst_sd", 32'(sd3), 32'd0);
    comprobar("rm_rst_fe", 32'(fe3), 32'd0);
    avanza();
    rst_n = 1'b1;
    #1;
    comprobar("rm_after_sd", 32'(sd3), 32'd0);
    comprobar("rm_after_cnt", cnt3,    32'd0);

    // Counter saturation with a 4-bit counter.
    reiniciar();
    pone_carga();
    repeat (15) avanza();
    #1;
    comprobar("sat_15", 32'(cntc), 32'd15);
    repeat (5) avanza();
    quita_carga();
    #1;
    comprobar("sat_hold", 32'(cntc), 32'd15);
    comprobar("wide_20",  cnt0,      32'd20);
    avanza();
    #1;
    comprobar("sat_idle", 32'(cntc), 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
